// File: rtl/uart_dbg_cmd_engine_if.sv
// Bundle of signals between the debug command engine and its neighbours:
// the UART RX byte stream, the UART TX byte handshake, and the register file's
// debugger access port.
//   master : the command engine (drives tx_* and reg_* outputs)
//   slave  : the UART/register-file side (drives rx_*, tx_ready, reg_rd_*)
interface uart_dbg_cmd_engine_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        reg_rd_done;

  modport master (
    input  rx_data, rx_valid, tx_ready, reg_rd_data, reg_rd_done,
    output tx_data, tx_valid, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, reg_rd_data, reg_rd_done,
    input  tx_data, tx_valid, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en
  );
endinterface

// File: rtl/uart_dbg_cmd_engine.sv
// UART debug command engine. Parses 'R' ADDR and 'W' ADDR D3 D2 D1 D0 frames
// from the RX byte stream, performs one register access over the debugger
// port, and streams the response (4 data bytes, 'K' or 'E') to UART TX.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : master side of uart_dbg_cmd_engine_if (rx, tx, reg_*)
//   busy        : high whenever the engine is not idle
//   err         : one-cycle pulse on protocol error, read timeout or
//                 inter-byte timeout
//   rx_overrun  : sticky flag, an rx byte arrived while it could not be taken
module uart_dbg_cmd_engine #(
  parameter int NUM_REGS       = 32,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int RD_WAIT_MAX    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_dbg_cmd_engine_if.master bus,
  output logic                  busy,
  output logic                  err,
  output logic                  rx_overrun
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GET_ADDR = 3'd1;
  localparam logic [2:0] S_GET_DATA = 3'd2;
  localparam logic [2:0] S_RD_REQ   = 3'd3;
  localparam logic [2:0] S_RD_WAIT  = 3'd4;
  localparam logic [2:0] S_WR_REQ   = 3'd5;
  localparam logic [2:0] S_SEND     = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  localparam logic [7:0] OP_RD    = 8'h52;
  localparam logic [7:0] OP_WR    = 8'h57;
  localparam logic [7:0] RESP_OK  = 8'h4B;
  localparam logic [7:0] RESP_ERR = 8'h45;

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RDW_W = $clog2(RD_WAIT_MAX + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [RDW_W-1:0] RDW_LAST = RDW_W'(RD_WAIT_MAX - 1);
  localparam logic [RDW_W-1:0] RDW_ONE  = RDW_W'(1);
  localparam logic [8:0]       ADDR_LIMIT = 9'(NUM_REGS);

  logic [2:0]       state_reg;
  logic             is_write_reg;
  logic [1:0]       byte_cnt_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [RDW_W-1:0] rdw_cnt_reg;
  logic [31:0]      resp_reg;      // response bytes, next byte in [31:24]
  logic [2:0]       resp_len_reg;  // bytes still to send
  logic             tmo_err_reg;
  logic             overrun_reg;
  logic [7:0]       addr_reg;
  logic [31:0]      wr_data_reg;

  logic tmo_hit;
  logic rx_blocked;

  // Idle cycles counted so far reach the limit on this cycle (no byte now).
  assign tmo_hit = (tmo_cnt_reg == TMO_LAST);

  // States that cannot take a byte: any strobe here is lost.
  assign rx_blocked = (state_reg == S_RD_REQ) || (state_reg == S_RD_WAIT) ||
                      (state_reg == S_WR_REQ) || (state_reg == S_SEND) ||
                      (state_reg == S_ERR);

  // Strobes are decoded from single-cycle states, so they can never overlap
  // and can never appear in consecutive cycles.
  assign bus.reg_rd_en   = (state_reg == S_RD_REQ);
  assign bus.reg_wr_en   = (state_reg == S_WR_REQ);
  assign bus.reg_addr    = addr_reg;
  assign bus.reg_wr_data = wr_data_reg;
  assign bus.tx_valid    = (state_reg == S_SEND);
  assign bus.tx_data     = resp_reg[31:24];
  assign busy            = (state_reg != S_IDLE);
  assign err             = (state_reg == S_ERR) || tmo_err_reg;
  assign rx_overrun      = overrun_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      is_write_reg <= 1'b0;
      byte_cnt_reg <= 2'd0;
      tmo_cnt_reg  <= '0;
      rdw_cnt_reg  <= '0;
      resp_reg     <= 32'd0;
      resp_len_reg <= 3'd0;
      tmo_err_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
      addr_reg     <= 8'd0;
      wr_data_reg  <= 32'd0;
    end else begin
      tmo_err_reg <= 1'b0;
      if (bus.rx_valid && rx_blocked) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == OP_RD || bus.rx_data == OP_WR) begin
              is_write_reg <= (bus.rx_data == OP_WR);
              tmo_cnt_reg  <= '0;
              state_reg    <= S_GET_ADDR;
            end else begin
              state_reg <= S_ERR;
            end
          end
        end

        S_GET_ADDR: begin
          if (bus.rx_valid) begin
            addr_reg    <= bus.rx_data;
            tmo_cnt_reg <= '0;
            if ({1'b0, bus.rx_data} >= ADDR_LIMIT) begin
              state_reg <= S_ERR;
            end else if (is_write_reg) begin
              byte_cnt_reg <= 2'd0;
              state_reg    <= S_GET_DATA;
            end else begin
              state_reg <= S_RD_REQ;
            end
          end else if (tmo_hit) begin
            // Abandoned frame: flag it but send nothing back.
            tmo_err_reg <= 1'b1;
            state_reg   <= S_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_ONE;
          end
        end

        S_GET_DATA: begin
          if (bus.rx_valid) begin
            wr_data_reg  <= {wr_data_reg[23:0], bus.rx_data};
            tmo_cnt_reg  <= '0;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              state_reg <= S_WR_REQ;
            end
          end else if (tmo_hit) begin
            tmo_err_reg <= 1'b1;
            state_reg   <= S_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_ONE;
          end
        end

        S_RD_REQ: begin
          rdw_cnt_reg <= '0;
          state_reg   <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          // A completion in the final allowed cycle still wins over the timeout.
          if (bus.reg_rd_done) begin
            resp_reg     <= bus.reg_rd_data;
            resp_len_reg <= 3'd4;
            state_reg    <= S_SEND;
          end else if (rdw_cnt_reg == RDW_LAST) begin
            state_reg <= S_ERR;
          end else begin
            rdw_cnt_reg <= rdw_cnt_reg + RDW_ONE;
          end
        end

        S_WR_REQ: begin
          resp_reg     <= {RESP_OK, 24'd0};
          resp_len_reg <= 3'd1;
          state_reg    <= S_SEND;
        end

        S_ERR: begin
          resp_reg     <= {RESP_ERR, 24'd0};
          resp_len_reg <= 3'd1;
          state_reg    <= S_SEND;
        end

        S_SEND: begin
          if (bus.tx_ready) begin
            resp_reg     <= {resp_reg[23:0], 8'd0};
            resp_len_reg <= resp_len_reg - 3'd1;
            if (resp_len_reg == 3'd1) begin
              state_reg <= S_IDLE;
            end
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_dbg_cmd_engine.md
Name: uart_dbg_cmd_engine

Overview:
Command engine between the UART receiver/transmitter and the core register file's debugger register interface. It parses byte-framed read and write commands from the UART RX byte stream. It issues single-cycle reg_rd_en or reg_wr_en accesses and streams the response bytes back to the UART TX path. It is the only master of the reg_* debugger interface.

Parameters:
NUM_REGS, 32, number of addressable registers; an address >= NUM_REGS is rejected.
TIMEOUT_CYCLES, 100000, idle cycles allowed between bytes of one frame before the frame is aborted.
RD_WAIT_MAX, 15, cycles to wait for reg_rd_done before the read is declared failed.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  received UART byte
rx_valid  in  1  single-cycle strobe; rx_data is valid this cycle; no backpressure
tx_data  out  8  response byte to UART TX
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  TX accepts the byte when tx_valid&&tx_ready
reg_addr  out  8  register index for the debugger interface
reg_wr_data  out  32  write data
reg_wr_en  out  1  one-cycle write strobe
reg_rd_en  out  1  one-cycle read strobe
reg_rd_data  in  32  read data; valid in the cycle reg_rd_done=1
reg_rd_done  in  1  read completion, nominally the cycle after reg_rd_en
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse on any protocol error or timeout
rx_overrun  out  1  sticky; set when an rx byte is dropped; cleared only by rst

Behaviour:
- Reset: the synchronous rst is sampled on the clk rising edge. All outputs go to 0 and the state goes to IDLE. A reset mid-frame or mid-transmit discards everything with no partial response.
- Frame formats (multi-byte fields MSB first):
  - read: 0x52 ('R'), ADDR. Response: D3 D2 D1 D0.
  - write: 0x57 ('W'), ADDR, D3 D2 D1 D0. Response: 0x4B ('K').
  - error response: single byte 0x45 ('E').
- States: IDLE, GET_ADDR, GET_DATA, RD_REQ, RD_WAIT, WR_REQ, SEND, ERR.
- IDLE:
  - rx 0x52 or 0x57: latch the opcode and go to GET_ADDR.
  - any other byte: go to ERR.
- GET_ADDR:
  - On an rx byte, latch it into reg_addr.
  - If addr >= NUM_REGS, go to ERR.
  - Otherwise a read goes to RD_REQ and a write goes to GET_DATA with byte count 0.
- GET_DATA: shift rx bytes into reg_wr_data. After the 4th byte, go to WR_REQ.
- WR_REQ: assert reg_wr_en for exactly 1 cycle. Load the response 0x4B (length 1) and go to SEND.
- RD_REQ: assert reg_rd_en for exactly 1 cycle and go to RD_WAIT.
- RD_WAIT:
  - When reg_rd_done=1, capture reg_rd_data, load a 4-byte response and go to SEND.
  - If RD_WAIT_MAX cycles pass without done, go to ERR.
  - reg_rd_data is ignored whenever done=0.
- SEND: present bytes in order. Advance only on tx_valid&&tx_ready. tx_data stays stable while tx_valid=1 and tx_ready=0. After the last byte is accepted, go to IDLE (tx_valid=0 in IDLE).
- ERR: pulse err for 1 cycle. Load the response 0x45 (length 1) and go to SEND.
- Inter-byte timeout:
  - The counter runs in GET_ADDR and GET_DATA and reloads on every rx_valid.
  - When it reaches TIMEOUT_CYCLES: pulse err, return to IDLE, send no response.
- Dropped bytes: an rx_valid in RD_REQ, RD_WAIT, WR_REQ, SEND or ERR drops the byte and sets rx_overrun. The FSM is unaffected.
- Strobe rules: reg_wr_en and reg_rd_en are never high together and are never high in consecutive cycles. reg_addr and reg_wr_data hold their value from latch until the next frame overwrites them.
- Latency:
  - final write byte -> reg_wr_en: 1 cycle.
  - ADDR byte -> reg_rd_en: 1 cycle.
  - reg_rd_done -> first tx_valid: 1 cycle.

Test Plan:
- Read: rx 0x52,0x05 with the register model returning 0xDEADBEEF on done -> exactly one reg_rd_en pulse with reg_addr=0x05, then tx DE AD BE EF in order, busy falls after the 4th handshake.
- Write: rx 0x57,0x0A,0x12,0x34,0x56,0x78 -> one reg_wr_en pulse with reg_addr=0x0A and reg_wr_data=0x12345678, tx 0x4B; no reg_rd_en at any point.
- Errors:
  - rx 0x41 -> err pulse, tx 0x45.
  - rx 0x52,0x20 (NUM_REGS=32) -> tx 0x45, no reg_rd_en.
- Backpressure and overrun: read of reg 3 with tx_ready low for 10 cycles per byte -> tx_data is stable while stalled and all 4 bytes are delivered. An rx byte injected during SEND sets rx_overrun, and the FSM completes normally.
- Timeouts:
  - TIMEOUT_CYCLES=50: rx 0x57,0x01,0xAA then silence -> err pulse at 50 idle cycles, IDLE, no tx, no reg_wr_en.
  - reg_rd_done held low -> tx 0x45 after RD_WAIT_MAX cycles.
- Reset mid-frame: assert rst during GET_DATA and during SEND -> all outputs 0 on the next edge. A following read frame for reg 1 completes correctly.
